// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: button indices, repeat-FSM states, default timing.
package stopwatch_pkg;

  // Button positions within the 4-bit debounced level vector
  localparam int unsigned BTN_START = 0;
  localparam int unsigned BTN_INC   = 1;
  localparam int unsigned BTN_RESET = 2;
  localparam int unsigned BTN_DEC   = 3;
  localparam int unsigned NUM_BTN   = 4;

  // Default timing at a 100 MHz system clock
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10_000_000;

  // Auto-repeat state for the inc/dec buttons
  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_WAIT = 2'd1,
    RS_RPT  = 2'd2
  } rpt_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser, stability-counter debounce, press detect.
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic lvl_o,
  output logic press_c_o
);

  localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic          lvl_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchroniser, debounce state and one-cycle-delayed level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= btn_i;
      s2_q      <= s1_q;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
      cnt_q     <= cnt_d;
    end
  end

  // Accept a new level only after it has differed from lvl for DEBOUNCE_CYCLES cycles
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    if (s2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      lvl_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign lvl_o     = lvl_q;
  // High for the single cycle after lvl rises; the top registers it into the output pulse
  assign press_c_o = lvl_q & ~lvl_dly_q;

endmodule

// File: rtl/button_conditioner.sv
// Stopwatch button front end: four debounced channels, inc/dec auto-repeat, reset priority.
module button_conditioner
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_inc,
  input  logic       btn_reset,
  input  logic       btn_dec,
  output logic       start,
  output logic       inc,
  output logic       reset,
  output logic       dec,
  output logic [3:0] held
);

  localparam int unsigned   NRPT        = 2;  // channel 0 = inc, channel 1 = dec
  localparam int unsigned   RPT_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                          : REPEAT_PERIOD;
  localparam int unsigned   RW          = cnt_width(RPT_MAX);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] lvl;
  logic [NUM_BTN-1:0] press_c;

  logic [NRPT-1:0]    rpt_lvl;
  logic [NRPT-1:0]    rpt_press;
  logic [NRPT-1:0]    rpt_c;
  logic               both_held_c;

  rpt_state_e         state_q [NRPT];
  rpt_state_e         state_d [NRPT];
  logic [RW-1:0]      rcnt_q  [NRPT];
  logic [RW-1:0]      rcnt_d  [NRPT];

  logic               start_q, inc_q, reset_q, dec_q;

  assign btn_raw = {btn_dec, btn_reset, btn_inc, btn_start};

  // One debounce channel per button
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_i     (btn_raw[g]),
      .lvl_o     (lvl[g]),
      .press_c_o (press_c[g])
    );
  end

  assign rpt_lvl     = {lvl[BTN_DEC], lvl[BTN_INC]};
  assign rpt_press   = {press_c[BTN_DEC], press_c[BTN_INC]};
  assign both_held_c = lvl[BTN_INC] & lvl[BTN_DEC];

  // Repeat FSM state and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NRPT; ch++) begin
        state_q[ch] <= RS_IDLE;
        rcnt_q[ch]  <= '0;
      end
    end else begin
      for (int ch = 0; ch < NRPT; ch++) begin
        state_q[ch] <= state_d[ch];
        rcnt_q[ch]  <= rcnt_d[ch];
      end
    end
  end

  // Repeat next-state: release or inc+dec together cancels any pending repeat at once
  always_comb begin
    for (int ch = 0; ch < NRPT; ch++) begin
      state_d[ch] = state_q[ch];
      rcnt_d[ch]  = rcnt_q[ch];
      rpt_c[ch]   = 1'b0;
      if (!rpt_lvl[ch] || both_held_c) begin
        state_d[ch] = RS_IDLE;
        rcnt_d[ch]  = '0;
      end else begin
        case (state_q[ch])
          RS_IDLE: begin
            if (rpt_press[ch]) begin
              state_d[ch] = RS_WAIT;
              rcnt_d[ch]  = '0;
            end
          end
          RS_WAIT: begin
            if (rcnt_q[ch] == DELAY_LAST) begin
              rpt_c[ch]   = 1'b1;
              state_d[ch] = RS_RPT;
              rcnt_d[ch]  = '0;
            end else begin
              rcnt_d[ch] = rcnt_q[ch] + RW'(1);
            end
          end
          RS_RPT: begin
            if (rcnt_q[ch] == PERIOD_LAST) begin
              rpt_c[ch]  = 1'b1;
              rcnt_d[ch] = '0;
            end else begin
              rcnt_d[ch] = rcnt_q[ch] + RW'(1);
            end
          end
          default: begin
            state_d[ch] = RS_IDLE;
            rcnt_d[ch]  = '0;
          end
        endcase
      end
    end
  end

  // Registered command pulses; a clear press drops any coincident start/inc/dec
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      inc_q   <= 1'b0;
      reset_q <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      start_q <= press_c[BTN_START] & ~press_c[BTN_RESET];
      inc_q   <= (press_c[BTN_INC] | rpt_c[0]) & ~press_c[BTN_RESET];
      reset_q <= press_c[BTN_RESET];
      dec_q   <= (press_c[BTN_DEC] | rpt_c[1]) & ~press_c[BTN_RESET];
    end
  end

  assign start = start_q;
  assign inc   = inc_q;
  assign reset = reset_q;
  assign dec   = dec_q;
  assign held  = lvl;

endmodule
